// File: rtl/hist_scaler_axis_pkg.sv
// Shared widths, config FSM states and the gain reference function for the histogram output scaler.
package hist_pkg;

    localparam int unsigned DIN_W  = 14;
    localparam int unsigned DOUT_W = 8;
    localparam int unsigned FRAC_W = 16;
    localparam int unsigned GAIN_W = DOUT_W + FRAC_W;
    localparam int unsigned PROD_W = DIN_W + GAIN_W;
    localparam int unsigned CNT_W  = $clog2(GAIN_W);

    // (2^DOUT_W - 1) << FRAC_W, the fixed numerator of every gain.
    localparam logic [GAIN_W-1:0] GAIN_NUM = {{DOUT_W{1'b1}}, {FRAC_W{1'b0}}};

    typedef enum logic [1:0] {
        CFG_IDLE = 2'd0,
        CFG_DIV  = 2'd1,
        CFG_RDY  = 2'd2
    } cfg_state_e;

    typedef struct packed {
        logic tuser;
        logic tlast;
    } axis_side_t;

    function automatic logic [GAIN_W-1:0] gain_calc(input logic [DIN_W-1:0] span);
        logic [GAIN_W-1:0] s;
        s = (span == '0) ? GAIN_W'(1) : GAIN_W'(span);
        return GAIN_NUM / s;
    endfunction

    localparam logic [GAIN_W-1:0] GAIN_DEF = gain_calc({DIN_W{1'b1}});

endpackage

// File: rtl/hist_scaler_axis_if.sv
// AXI-Stream beat bundle with sideband SOF (tuser) and EOL (tlast).
interface hist_scaler_axis_if #(
    parameter int unsigned W = 8
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tuser;
    logic         tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/hist_scaler_axis_recip_div.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, GAIN_W cycles per division.
module hist_recip_div
    import hist_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              start_i,
    input  logic [GAIN_W-1:0] dividend_i,
    input  logic [DIN_W-1:0]  divisor_i,
    output logic              busy_o,
    output logic              done_c,
    output logic [GAIN_W-1:0] quot_o
);

    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DIN_W-1:0]  rem_q;
    logic [DIN_W-1:0]  rem_d;
    logic [DIN_W-1:0]  dvs_q;
    logic [GAIN_W-1:0] quot_q;
    logic [DIN_W:0]    trial_c;
    logic              ge_c;

    // Remainder stays below the divisor, so one extra bit holds the shifted trial value.
    always_comb begin
        trial_c = {rem_q, quot_q[GAIN_W-1]};
        ge_c    = (trial_c >= {1'b0, dvs_q});
        rem_d   = ge_c ? DIN_W'(trial_c - {1'b0, dvs_q}) : DIN_W'(trial_c);
    end

    assign done_c = busy_q && (cnt_q == CNT_W'(GAIN_W - 1));
    assign busy_o = busy_q;
    assign quot_o = quot_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            quot_q <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
            quot_q <= dividend_i;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quot_q <= {quot_q[GAIN_W-2:0], ge_c};
            cnt_q  <= cnt_q + CNT_W'(1);
            if (done_c) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hist_scaler_axis.sv
// Window-and-gain scaler from DIN_W-bit samples to DOUT_W-bit video, with frame-synchronous config commit.
module hist_scaler_axis
    import hist_pkg::*;
(
    input  logic               clk,
    input  logic               srst,
    input  logic [DIN_W-1:0]   cfg_lo,
    input  logic [DIN_W-1:0]   cfg_hi,
    input  logic               cfg_valid,
    output logic               cfg_busy,
    output logic               cfg_pending,
    hist_scaler_axis_if.slave  s_axis,
    hist_scaler_axis_if.master m_axis
);

    localparam int unsigned       Q_W     = PROD_W - FRAC_W + 1;
    localparam logic [PROD_W:0]   RND     = (PROD_W + 1)'(1) << (FRAC_W - 1);
    localparam logic [Q_W-1:0]    OUT_MAX = Q_W'((1 << DOUT_W) - 1);

    cfg_state_e        state_q, state_d;
    logic              pend_q;
    logic [DIN_W-1:0]  pend_lo_q;
    logic [DIN_W-1:0]  act_lo_q;
    logic [GAIN_W-1:0] act_gain_q;
    logic [GAIN_W-1:0] div_quot;
    logic              div_busy;
    logic              div_done_c;
    logic              commit_c;
    logic              en_c;
    logic              s_fire_c;
    logic [DIN_W-1:0]  span_c;
    logic [DIN_W-1:0]  lo_use_c;
    logic [Q_W-1:0]    q_c;
    logic [DOUT_W-1:0] sat_c;

    logic              v1_q, v2_q, v3_q;
    axis_side_t        sd1_q, sd2_q, sd3_q;
    logic [DIN_W-1:0]  d1_q;
    logic [PROD_W-1:0] p2_q;
    logic [DOUT_W-1:0] q3_q;

    assign en_c          = ~v3_q | m_axis.tready;
    assign s_axis.tready = en_c;
    assign s_fire_c      = s_axis.tvalid & en_c;
    assign span_c        = (cfg_hi > cfg_lo) ? DIN_W'(cfg_hi - cfg_lo) : DIN_W'(1);

    hist_recip_div u_div (
        .clk        (clk),
        .srst       (srst),
        .start_i    (cfg_valid),
        .dividend_i (GAIN_NUM),
        .divisor_i  (span_c),
        .busy_o     (div_busy),
        .done_c     (div_done_c),
        .quot_o     (div_quot)
    );

    // Config FSM: a fresh strobe always wins, even on the commit cycle.
    always_comb begin
        state_d  = state_q;
        commit_c = 1'b0;
        case (state_q)
            CFG_DIV: if (div_done_c) state_d = CFG_RDY;
            CFG_RDY: begin
                if (s_fire_c && s_axis.tuser) begin
                    commit_c = 1'b1;
                    state_d  = CFG_IDLE;
                end
            end
            default: ;
        endcase
        if (cfg_valid) begin
            state_d = CFG_DIV;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= CFG_IDLE;
            pend_q     <= 1'b0;
            pend_lo_q  <= '0;
            act_lo_q   <= '0;
            act_gain_q <= GAIN_DEF;
        end else begin
            state_q <= state_d;
            pend_q  <= (state_d == CFG_RDY);
            if (cfg_valid) begin
                pend_lo_q <= cfg_lo;
            end
            if (commit_c) begin
                act_lo_q   <= pend_lo_q;
                act_gain_q <= div_quot;
            end
        end
    end

    assign cfg_busy    = div_busy;
    assign cfg_pending = pend_q;

    // The SOF beat that commits must already see the new lo; the new gain is in place by its S2 step.
    always_comb begin
        lo_use_c = commit_c ? pend_lo_q : act_lo_q;
        q_c      = Q_W'(((PROD_W + 1)'({1'b0, p2_q}) + RND) >> FRAC_W);
        sat_c    = (q_c > OUT_MAX) ? {DOUT_W{1'b1}} : DOUT_W'(q_c);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            sd1_q <= '0;
            sd2_q <= '0;
            sd3_q <= '0;
            d1_q  <= '0;
            p2_q  <= '0;
            q3_q  <= '0;
        end else if (en_c) begin
            v1_q  <= s_axis.tvalid;
            sd1_q <= '{tuser: s_axis.tuser, tlast: s_axis.tlast};
            d1_q  <= (s_axis.tdata > lo_use_c) ? DIN_W'(s_axis.tdata - lo_use_c) : '0;
            v2_q  <= v1_q;
            sd2_q <= sd1_q;
            p2_q  <= PROD_W'(d1_q) * PROD_W'(act_gain_q);
            v3_q  <= v2_q;
            sd3_q <= sd2_q;
            q3_q  <= sat_c;
        end
    end

    assign m_axis.tvalid = v3_q;
    assign m_axis.tdata  = q3_q;
    assign m_axis.tuser  = sd3_q.tuser;
    assign m_axis.tlast  = sd3_q.tlast;

endmodule
